// File: rtl/uart_pkg.sv
// uart_pkg: shared UART widths, receiver state encoding and divisor clamp helper.
package uart_pkg;
    localparam int UART_DATA_W = 8;
    localparam int UART_BAUD_W = 16;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;
    function automatic logic [UART_BAUD_W-1:0] clamp_div(input logic [UART_BAUD_W-1:0] b, input logic [UART_BAUD_W-1:0] m);
        return (b < m) ? m : b;
    endfunction
endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for asynchronous pin inputs, reset to RST_VAL.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) {q, meta} <= {2{RST_VAL}};
        else        {q, meta} <= {meta, d};
    end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1/8E1/8N2/8E2 UART receiver with centre sampling.
// Define UART_RX_ERR_EN to deliver errored bytes flagged on parity_err_o/frame_err_o instead of dropping them.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned MIN_DIV = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   rx_i,
    input  logic [UART_BAUD_W-1:0] baudrate_i,
    input  logic                   parity_en_i,
    input  logic                   stopbit_i,
    output logic                   busy_o,
    output logic [UART_DATA_W-1:0] rx_data_o,
`ifdef UART_RX_ERR_EN
    output logic                   parity_err_o,
    output logic                   frame_err_o,
`endif
    output logic                   rx_valid_o
);
    localparam logic [UART_BAUD_W-1:0] MIN_D = UART_BAUD_W'(MIN_DIV);
    rx_state_e state_q, state_d;
    logic [UART_BAUD_W-1:0] cnt_q, cnt_d, div_q, div_d;
    logic [2:0] bit_q, bit_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d, data_d;
    logic par_q, par_d, two_q, two_d, second_q, second_d;
    logic perr_q, perr_d, ferr_q, ferr_d, valid_d;
    logic rx_s, rx_d, fall, tick, stop_bad;
`ifdef UART_RX_ERR_EN
    logic pe_d, fe_d;
`endif
    uart_sync2 u_sync (.clk_i(clk_i), .rst_i(rst_i), .d(rx_i), .q(rx_s));
    assign fall     = rx_d & ~rx_s;
    assign tick     = cnt_q == '0;
    assign stop_bad = ferr_q | ~rx_s;
    assign busy_o   = (state_q != IDLE) | fall;
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            rx_d       <= 1'b1;
            cnt_q      <= '0;
            div_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            two_q      <= 1'b0;
            second_q   <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            rx_data_o  <= '0;
            rx_valid_o <= 1'b0;
`ifdef UART_RX_ERR_EN
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rx_d       <= rx_s;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            two_q      <= two_d;
            second_q   <= second_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            rx_data_o  <= data_d;
            rx_valid_o <= valid_d;
`ifdef UART_RX_ERR_EN
            parity_err_o <= pe_d;
            frame_err_o  <= fe_d;
`endif
        end
    end
    // cnt reloads to a full bit period on every sample tick; IDLE overrides it.
    always_comb begin
        state_d  = state_q;
        cnt_d    = tick ? div_q - 1'b1 : cnt_q - 1'b1;
        div_d    = div_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_d    = par_q;
        two_d    = two_q;
        second_d = second_q;
        perr_d   = perr_q;
        ferr_d   = ferr_q;
        data_d   = rx_data_o;
        valid_d  = 1'b0;
`ifdef UART_RX_ERR_EN
        pe_d     = 1'b0;
        fe_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (fall) begin
                    div_d    = clamp_div(baudrate_i, MIN_D);
                    cnt_d    = div_d >> 1;
                    par_d    = parity_en_i;
                    two_d    = stopbit_i;
                    second_d = 1'b0;
                    perr_d   = 1'b0;
                    ferr_d   = 1'b0;
                    state_d  = START;
                end
            end
            START: begin
                if (tick) begin
                    bit_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = {rx_s, shift_q[UART_DATA_W-1:1]};
                    bit_d   = bit_q + 3'd1;
                    state_d = (bit_q != 3'd7) ? DATA : par_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (tick) begin
                    perr_d  = ^{shift_q, rx_s};
                    state_d = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    ferr_d   = stop_bad;
                    second_d = 1'b1;
                    if (!two_q || second_q) begin
                        state_d = IDLE;
`ifdef UART_RX_ERR_EN
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        pe_d    = perr_q;
                        fe_d    = stop_bad;
`else
                        if (!(perr_q | stop_bad)) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
